// File: rtl/uart_frame_decoder_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder_pkg
// Shared definitions for the UART frame decoder slice:
//   state_t   - decoder FSM state encoding (IDLE=0, LEN=1, PAYLOAD=2, CHECK=3)
//   err_t     - frame_error cause codes (NONE=0, LEN=1, CHK=2, TIMEOUT=3)
//   len_legal - LEN byte range check (1..max_len)
// -----------------------------------------------------------------------------
package uart_frame_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CHK     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
      return (len != 8'd0) && (len <= max_len);
   endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder_if
// Byte-in / frame-out bundle of the UART frame decoder.
//   rx_data, rx_ready       : received byte and its ready level from uart_rx
//   payload_data/_valid     : streamed payload bytes (one-cycle strobe)
//   frame_done, frame_error : one-cycle end-of-frame pulses, err_code = cause
//   frame_len               : LEN of current/last frame
//   busy, state             : decoder activity and FSM state for observation
// Handshake: there is no backpressure. A rising edge of rx_ready marks one new
// byte on rx_data; every payload_valid cycle carries one byte that the consumer
// must take in that cycle. frame_done/frame_error close each frame exactly once.
// Modports: slave = decoder, master = upstream driver / downstream observer.
// -----------------------------------------------------------------------------
interface uart_frame_decoder_if;
   import uart_frame_decoder_pkg::*;

   logic [7:0] rx_data;
   logic       rx_ready;
   logic [7:0] payload_data;
   logic       payload_valid;
   logic       frame_done;
   logic       frame_error;
   logic [1:0] err_code;
   logic [7:0] frame_len;
   logic       busy;
   state_t     state;

   modport slave (
      input  rx_data, rx_ready,
      output payload_data, payload_valid, frame_done, frame_error,
             err_code, frame_len, busy, state
   );

   modport master (
      output rx_data, rx_ready,
      input  payload_data, payload_valid, frame_done, frame_error,
             err_code, frame_len, busy, state
   );
endinterface

// File: rtl/uart_frame_decoder_byte_strobe.sv
// -----------------------------------------------------------------------------
// uart_byte_strobe
// Rising-edge detector turning a ready level into a one-cycle byte strobe.
//   clk, reset : clock, asynchronous active-low reset
//   level      : ready level (uart_rx.ready or a TX-done level)
//   strobe     : level & ~previous level
// The history flop resets to 1 so a level already high when reset releases is
// not mistaken for a new byte.
// -----------------------------------------------------------------------------
module uart_byte_strobe (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic strobe
);
   logic level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) level_q <= 1'b1;
      else        level_q <= level;
   end

   assign strobe = level & ~level_q;
endmodule

// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
// Delimits SYNC, LEN, payload[LEN], CHK frames from a received byte stream and
// streams payload bytes as they arrive. CHK is the XOR of LEN and the payload.
//   SYNC_BYTE      : frame start marker
//   MAX_LEN        : largest legal LEN (1..255)
//   TIMEOUT_CYCLES : idle cycles allowed between bytes inside a frame (>= 2)
//   clk, reset     : clock, asynchronous active-low reset
//   bus            : uart_frame_decoder_if.slave (byte in, payload/frame out)
// All outputs come from registers; a byte consumed on an edge shows its effect
// in the following cycle only.
// -----------------------------------------------------------------------------
module uart_frame_decoder
   import uart_frame_decoder_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_frame_decoder_if.slave    bus
);
   localparam int         TO_W      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   logic            strobe;
   state_t          state;
   logic [7:0]      remaining;
   logic [7:0]      chk;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      payload_data_q;
   logic            payload_valid_q;
   logic            frame_done_q;
   logic            frame_error_q;
   err_t            err_code_q;
   logic [7:0]      frame_len_q;

   uart_byte_strobe u_strobe (
      .clk    (clk),
      .reset  (reset),
      .level  (bus.rx_ready),
      .strobe (strobe)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         remaining       <= 8'd0;
         chk             <= 8'd0;
         to_cnt          <= '0;
         payload_data_q  <= 8'd0;
         payload_valid_q <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_error_q   <= 1'b0;
         err_code_q      <= ERR_NONE;
         frame_len_q     <= 8'd0;
      end else begin
         payload_valid_q <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_error_q   <= 1'b0;

         // Inter-byte idle counter; saturates at the terminal count.
         if (strobe || state == ST_IDLE) to_cnt <= '0;
         else if (to_cnt != TO_LAST)     to_cnt <= to_cnt + 1'b1;

         if (strobe) begin
            // A byte wins over a coincident terminal count.
            case (state)
               ST_IDLE: begin
                  if (bus.rx_data == SYNC_BYTE) state <= ST_LEN;
               end
               ST_LEN: begin
                  if (len_legal(bus.rx_data, MAX_LEN_B)) begin
                     frame_len_q <= bus.rx_data;
                     remaining   <= bus.rx_data;
                     chk         <= bus.rx_data;
                     state       <= ST_PAYLOAD;
                  end else begin
                     frame_error_q <= 1'b1;
                     err_code_q    <= ERR_LEN;
                     state         <= ST_IDLE;
                  end
               end
               ST_PAYLOAD: begin
                  payload_data_q  <= bus.rx_data;
                  payload_valid_q <= 1'b1;
                  chk             <= chk ^ bus.rx_data;
                  remaining       <= remaining - 8'd1;
                  if (remaining == 8'd1) state <= ST_CHECK;
               end
               ST_CHECK: begin
                  if (bus.rx_data == chk) begin
                     frame_done_q <= 1'b1;
                  end else begin
                     frame_error_q <= 1'b1;
                     err_code_q    <= ERR_CHK;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_TIMEOUT;
            state         <= ST_IDLE;
         end
      end
   end

   assign bus.payload_data  = payload_data_q;
   assign bus.payload_valid = payload_valid_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.frame_error   = frame_error_q;
   assign bus.err_code      = err_code_q;
   assign bus.frame_len     = frame_len_q;
   assign bus.busy          = (state != ST_IDLE);
   assign bus.state         = state;
endmodule
